memwb: RTL

Memory/writeback stage: final stage of the in-order pipeline, directly downstream of the execute stage. Accepts one instruction per handshake and performs at most one 16-bit or 8-bit data-bus transaction per instruction via a req/ack handshake. Drives the register-file write port with a one-cycle write-enable pulse, and reports bus faults back to execute as a one-cycle exception pulse.

---
 rtl/memwb_pkg.sv | 10 +
 rtl/memwb_mem_lane.sv | 32 +++
 rtl/memwb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/memwb_pkg.sv
// Shared widths and FSM encoding for the memory/writeback stage.
package memwb_pkg;
  localparam int MEMWB_RW    = 16;
  localparam int MEMWB_REGNO = 8;

  typedef enum logic {
    MEMWB_IDLE = 1'b0,
    MEMWB_BUS  = 1'b1
  } memwb_state_e;
endpackage

// File: rtl/memwb_mem_lane.sv
// Byte-lane steering: store select/data on the way out, load extraction on the way back.
module memwb_mem_lane
  import memwb_pkg::*;
#(
  parameter int RW = MEMWB_RW
) (
  input  logic          st_a0_i,
  input  logic          st_byte_i,
  input  logic [RW-1:0] st_data_i,
  output logic [1:0]    sel_o,
  output logic [RW-1:0] wdata_o,
  input  logic [RW-1:0] rdata_i,
  input  logic          ld_a0_i,
  input  logic          ld_byte_i,
  output logic [RW-1:0] ldata_o
);
  always_comb begin
    sel_o   = 2'b11;
    wdata_o = st_data_i;
    if (st_byte_i) begin
      sel_o   = st_a0_i ? 2'b10 : 2'b01;
      wdata_o = {(RW/8){st_data_i[7:0]}};
    end
  end

  // Byte loads come back zero-extended from whichever lane was addressed.
  always_comb begin
    ldata_o = rdata_i;
    if (ld_byte_i)
      ldata_o = RW'(ld_a0_i ? rdata_i[15:8] : rdata_i[7:0]);
  end
endmodule

// File: rtl/memwb.sv
// Memory/writeback stage: one bus transaction per memory op, one-cycle
// register-file write pulse, one-cycle exception pulse on bus fault.
module memwb
  import memwb_pkg::*;
#(
  parameter int RW    = MEMWB_RW,
  parameter int REGNO = MEMWB_REGNO
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  input  logic             i_mem_width,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [RW-2:0]    o_mem_addr,
  output logic [1:0]       o_mem_sel,
  output logic [RW-1:0]    o_mem_wdata,
  input  logic             i_mem_ack,
  input  logic [RW-1:0]    i_mem_rdata,
  input  logic             i_mem_fault,
  output logic             o_exception
);
  memwb_state_e     state_q;
  logic [REGNO-1:0] ie_q;
  logic             a0_q;
  logic             byte_q;
  logic [REGNO-1:0] reg_ie_q;
  logic [RW-1:0]    reg_data_q;
  logic             exc_q;
  logic             we_q;
  logic [RW-2:0]    addr_q;
  logic [1:0]       sel_q;
  logic [RW-1:0]    wdata_q;

  logic [1:0]       sel_d;
  logic [RW-1:0]    wdata_d;
  logic [RW-1:0]    ldata_d;
  logic             accept;

  assign o_ready = (state_q == MEMWB_IDLE);
  assign accept  = i_submit & o_ready;

  memwb_mem_lane #(.RW(RW)) u_lane (
    .st_a0_i   (i_addr[0]),
    .st_byte_i (i_mem_width),
    .st_data_i (i_data),
    .sel_o     (sel_d),
    .wdata_o   (wdata_d),
    .rdata_i   (i_mem_rdata),
    .ld_a0_i   (a0_q),
    .ld_byte_i (byte_q),
    .ldata_o   (ldata_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= MEMWB_IDLE;
      ie_q       <= '0;
      a0_q       <= 1'b0;
      byte_q     <= 1'b0;
      reg_ie_q   <= '0;
      reg_data_q <= '0;
      exc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
    end else begin
      reg_ie_q <= '0;
      exc_q    <= 1'b0;
      case (state_q)
        MEMWB_IDLE: begin
          if (accept) begin
            if (i_mem_access) begin
              ie_q    <= i_reg_ie;
              a0_q    <= i_addr[0];
              byte_q  <= i_mem_width;
              we_q    <= i_mem_we;
              addr_q  <= i_addr[RW-1:1];
              sel_q   <= sel_d;
              wdata_q <= wdata_d;
              state_q <= MEMWB_BUS;
            end else begin
              reg_ie_q   <= i_reg_ie;
              reg_data_q <= i_data;
            end
          end
        end
        MEMWB_BUS: begin
          // Fault wins over a simultaneous ack: the load result is discarded.
          if (i_mem_fault) begin
            exc_q   <= 1'b1;
            state_q <= MEMWB_IDLE;
          end else if (i_mem_ack) begin
            reg_data_q <= ldata_d;
            reg_ie_q   <= we_q ? '0 : ie_q;
            state_q    <= MEMWB_IDLE;
          end
        end
        default: state_q <= MEMWB_IDLE;
      endcase
    end
  end

  assign o_mem_req   = (state_q == MEMWB_BUS);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_sel   = sel_q;
  assign o_mem_wdata = wdata_q;
  assign o_reg_ie    = reg_ie_q;
  assign o_reg_data  = reg_data_q;
  assign o_exception = exc_q;
endmodule
